// File: rtl/mc_bus_arbiter_if.sv
// mc_bus_arbiter_if: shared multiplexed bus bundle between two masters and mc_bus_arbiter
//   req[1:0]       per-master level request
//   AddrValid, rw  address-cycle strobe and direction
//   AddrData       shared bus, [15:12] page, [11:0] loc
//   gnt, sel       one-hot grant and controller select
//   selRw, beat    latched direction and data beat index of the active burst
//   busy, decErr, tmo  status and one-cycle error pulses
// master modport: bus master side; slave modport: arbiter side
interface mc_bus_arbiter_if #(
    parameter int BUSWIDTH = 16,
    parameter int PAYLOAD  = 4
);
    localparam int BW = PAYLOAD > 1 ? $clog2(PAYLOAD) : 1;
    logic [1:0]          req;
    logic                AddrValid;
    logic                rw;
    logic [BUSWIDTH-1:0] AddrData;
    logic [1:0]          gnt;
    logic [1:0]          sel;
    logic                selRw;
    logic [BW-1:0]       beat;
    logic                busy;
    logic                decErr;
    logic                tmo;
    modport master (output req, AddrValid, rw, AddrData,
                    input  gnt, sel, selRw, beat, busy, decErr, tmo);
    modport slave  (input  req, AddrValid, rw, AddrData,
                    output gnt, sel, selRw, beat, busy, decErr, tmo);
endinterface

// File: rtl/mc_bus_arbiter.sv
// mc_bus_arbiter: round-robin arbiter and burst sequencer for the shared memory-controller bus
//   clk     system clock, rising edge
//   resetH  asynchronous active-high reset
//   bus     mc_bus_arbiter_if.slave (requests/address in, grant/select/status out)
// Optional feature: define MCARB_TIMEOUT_EN to abandon a grant whose master
// never drives AddrValid within TMO_CYC cycles.
module mc_bus_arbiter #(
    parameter int       BUSWIDTH = 16,
    parameter int       PAYLOAD  = 4,
    parameter logic [3:0] PAGE_A = 4'h2,
    parameter logic [3:0] PAGE_B = 4'hF,
    parameter int       TMO_CYC  = 8
) (
    input logic              clk,
    input logic              resetH,
    mc_bus_arbiter_if.slave  bus
);
    localparam int BW = PAYLOAD > 1 ? $clog2(PAYLOAD) : 1;
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t        state, state_n;
    logic [1:0]    gnt_n, sel_n;
    logic          sel_rw_n, dec_n, tmo_n;
    logic [BW-1:0] beat_n;
    logic          last, last_n;
    logic [3:0]    page;
    logic          addr_tmo;
    logic          unused_loc;
    assign page       = bus.AddrData[BUSWIDTH-1 -: 4];
    assign unused_loc = ^bus.AddrData[BUSWIDTH-5:0];
    assign bus.busy   = state != IDLE;
`ifdef MCARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge resetH)
        if (resetH) cnt <= '0;
        else        cnt <= state == ADDR ? cnt + 1'b1 : '0;
    assign addr_tmo = cnt == CW'(TMO_CYC - 1);
`else
    logic unused_tmo_cyc;
    assign unused_tmo_cyc = |TMO_CYC;
    assign addr_tmo       = 1'b0;
`endif
    always_comb begin
        state_n  = state;
        gnt_n    = bus.gnt;
        sel_n    = bus.sel;
        sel_rw_n = bus.selRw;
        beat_n   = bus.beat;
        last_n   = last;
        dec_n    = 1'b0;
        tmo_n    = 1'b0;
        unique case (state)
            IDLE: if (|bus.req) begin
                // on contention the master that did not win last time gets the bus
                gnt_n   = bus.req == 2'b11 ? (last ? 2'b01 : 2'b10) : bus.req;
                last_n  = gnt_n[1];
                state_n = ADDR;
            end
            ADDR: if (bus.AddrValid) begin
                if (page == PAGE_A || page == PAGE_B) begin
                    sel_n    = page == PAGE_A ? 2'b01 : 2'b10;
                    sel_rw_n = bus.rw;
                    beat_n   = '0;
                    state_n  = DATA;
                end else begin
                    dec_n   = 1'b1;
                    gnt_n   = 2'b00;
                    state_n = IDLE;
                end
            end else if (addr_tmo) begin
                tmo_n   = 1'b1;
                gnt_n   = 2'b00;
                state_n = IDLE;
            end
            DATA: if (bus.beat == BW'(PAYLOAD - 1)) begin
                gnt_n   = 2'b00;
                sel_n   = 2'b00;
                beat_n  = '0;
                state_n = IDLE;
            end else begin
                beat_n = bus.beat + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge resetH)
        if (resetH) begin
            state      <= IDLE;
            bus.gnt    <= 2'b00;
            bus.sel    <= 2'b00;
            bus.selRw  <= 1'b0;
            bus.beat   <= '0;
            bus.decErr <= 1'b0;
            bus.tmo    <= 1'b0;
            last       <= 1'b1;
        end else begin
            state      <= state_n;
            bus.gnt    <= gnt_n;
            bus.sel    <= sel_n;
            bus.selRw  <= sel_rw_n;
            bus.beat   <= beat_n;
            bus.decErr <= dec_n;
            bus.tmo    <= tmo_n;
            last       <= last_n;
        end
endmodule

// File: doc/mc_bus_arbiter.md
# mc_bus_arbiter

Arbiter and transaction sequencer for the shared 16-bit multiplexed address/data bus of the memory controller subsystem. Two bus masters request the bus; the block grants it round-robin, decodes the page field of the address cycle, selects the matching memory controller (page 4'h2 or 4'hF) and holds grant and select for the full DATAPAYLOADSIZE-word burst. It sits between the masters and the memory controllers and owns all bus-ownership sequencing.

## Interface
- BUSWIDTH, 16, width of AddrData
- PAYLOAD, 4, data beats per transaction (matches DATAPAYLOADSIZE)
- PAGE_A, 4'h2, page decoded to controller 0 (MEMPAGE1)
- PAGE_B, 4'hF, page decoded to controller 1 (MEMPAGE2)
- TMO_CYC, 8, cycles a grant may wait for AddrValid (used only with MCARB_TIMEOUT_EN)

- clk  in  1  system clock, rising edge
- resetH  in  1  asynchronous, active-high reset
- req  in  2  per-master bus request, level
- AddrValid  in  1  granted master drives address this cycle
- rw  in  1  1 = read, 0 = write; sampled with AddrValid
- AddrData  in  BUSWIDTH  shared bus; bits [15:12] = page, [11:0] = loc
- gnt  out  2  one-hot bus grant
- sel  out  2  one-hot controller select (bit0 = PAGE_A, bit1 = PAGE_B)
- selRw  out  1  latched rw for the active burst
- beat  out  $clog2(PAYLOAD)  current data beat index
- busy  out  1  high in any state other than IDLE
- decErr  out  1  one-cycle pulse: address page unmapped
- tmo  out  1  one-cycle pulse: grant timed out

## Operation
- Reset: gnt=0, sel=0, selRw=0, beat=0, busy=0, decErr=0, tmo=0, state=IDLE, lastGnt=1 (master 0 wins first contention).
- States: IDLE, ADDR, DATA.
- IDLE: if req!=0, grant one master (registered); if both request, grant the master not equal to lastGnt; update lastGnt; -> ADDR.
- ADDR: gnt held. On AddrValid: page = AddrData[15:12]; PAGE_A -> sel=01, PAGE_B -> sel=10, latch rw into selRw, beat=0, -> DATA. Any other page -> decErr pulse, gnt cleared, -> IDLE.
- DATA: sel, gnt, selRw held; beat increments each cycle 0..PAYLOAD-1; after beat PAYLOAD-1, gnt/sel/beat clear -> IDLE.
- req deassertion by the granted master in ADDR/DATA is ignored; burst always completes (or times out).
- AddrValid outside ADDR is ignored; AddrValid from a non-granted master is not distinguishable and is the bus's responsibility.
- resetH asserted mid-burst: all outputs clear immediately (async), lastGnt returns to 1.

## Timing
- req sampled at edge N -> gnt high from cycle N+1.
- AddrValid legal from the first cycle gnt is high; sampled at edge M -> sel, selRw valid, beat=0 from cycle M+1.
- sel held exactly PAYLOAD cycles (M+1..M+PAYLOAD); gnt falls at edge ending beat PAYLOAD-1.
- Minimum one IDLE cycle between bursts: back-to-back grants are separated by one cycle with gnt=0.
- decErr asserted the cycle after the offending AddrValid edge; gnt=0 in that same cycle.
- Arbitration latency worst case with both masters busy: PAYLOAD+3 cycles from req to gnt.

## Configuration
- MCARB_TIMEOUT_EN defined: counter runs in ADDR; if AddrValid not seen within TMO_CYC cycles of grant, tmo pulses one cycle, gnt clears, -> IDLE; lastGnt still updated (timed-out master loses next contention).
- Undefined: ADDR waits indefinitely; tmo tied 0; no counter logic.

## Test plan
- Reset then req=01, AddrValid with AddrData=16'h2040, rw=1 -> gnt=01, sel=01 for 4 cycles, beat 0,1,2,3, selRw=1, then gnt=00.
- req=11 continuously, pages 4'hF then 4'h2 -> grants alternate 01,10,01…, one gnt=00 cycle between bursts, sel matches page each burst.
- Address 16'h5000 -> decErr one cycle, sel stays 00, gnt clears, next requester granted after IDLE.
- Granted master drops req on beat 1 -> burst completes all 4 beats unchanged.
- resetH pulsed during beat 2 -> gnt, sel, beat, busy go 0 without clock edge; after release req=11 grants master 0 first.
- MCARB_TIMEOUT_EN, grant with no AddrValid for 8 cycles -> tmo pulse, gnt=00, other pending master granted next.
